vco_mp_cal: RTL

Parametrised multi-phase behavioural VCO model with an on-chip coarse-band (cfs) auto-calibration engine, clocked by the PLL reference clock.
- The oscillator core extends the single-phase VCO to NPH equally spaced output phases, a parametrised cfs width, and glitch-free band switching at half-period boundaries.
- The calibration FSM binary-searches cfs so the free-running frequency at mid control voltage lands at or just below a target count.
- Sits between the loop filter (differential Voutp/Voutn) and the feedback divider in the PLL linear model.

---
 rtl/vco_pkg.sv | 42 ++++
 rtl/vco_mp_core.sv | 81 ++++++++
 rtl/vco_mp_cal.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vco_pkg.sv
// Shared types, defaults and the frequency law for the multi-phase VCO with
// coarse-band auto-calibration.
package vco_pkg;

  // Calibration sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    DECIDE,
    DONE
  } cal_state_e;

  // Default model constants
  localparam int  DEF_CFS_W      = 6;
  localparam int  DEF_NPH        = 4;
  localparam real DEF_VIN_MAX    = 1.0;
  localparam real DEF_KVCO       = 1.0e9;
  localparam real DEF_MIN_FREQ   = 2.0e9;
  localparam real DEF_STEP       = 0.0378e9;
  localparam int  DEF_SETTLE_CYC = 4;
  localparam int  DEF_WIN_CYC    = 16;
  localparam int  DEF_CNT_W      = 12;
  localparam int  DEF_TARGET_CNT = 480;
  localparam real DEF_T_CLK_NS   = 10.0;

  // Width of the per-clk rising-edge count handed from the core to the top
  localparam int RISE_W = 8;

  // Output frequency (Hz) for a control voltage and band code; the control
  // voltage is clamped to [0, vin_max] before the gain is applied.
  function automatic real freq_of(input real vcont, input int unsigned cfs,
                                  input real vin_max, input real kvco,
                                  input real min_freq, input real step);
    real v;
    v = vcont;
    if (v <= 0.0) v = 0.0;
    else if (v >= vin_max) v = vin_max;
    return v * kvco + min_freq + real'(cfs) * step;
  endfunction

endpackage

// File: rtl/vco_mp_core.sv
// Behavioural multi-phase oscillator evaluated once per reference clock.
// Each phase keeps its own next-toggle time (ns, relative to the start of the
// current clk interval) and its own half period. A half period is re-derived
// from freq_i only at that phase's own toggle, so a frequency change never
// shortens a half period already in flight (no runt pulses).
module vco_mp_core
  import vco_pkg::*;
#(
  parameter int  NPH      = DEF_NPH,
  parameter real T_CLK_NS = DEF_T_CLK_NS,
  parameter int  MAX_TOG  = 128
) (
  input  logic              clk,
  input  logic              halt_i,
  input  real               freq_i,
  output logic [NPH-1:0]    oclk_o,
  output logic [RISE_W-1:0] rise_o
);

  logic              run_q;
  logic [NPH-1:0]    lvl_q, lvl_d;
  logic [RISE_W-1:0] rise_q, rise_d;
  real               tn_q [NPH];
  real               tn_d [NPH];
  real               hp_q [NPH];
  real               hp_d [NPH];

  // Advance every phase across one clk interval and count oclk[0] rises
  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    for (int k = 0; k < NPH; k++) begin
      tn_d[k] = tn_q[k];
      hp_d[k] = hp_q[k];
    end
    // First interval after release: phase k first toggles k*2*tt1/NPH in
    if (!run_q) begin
      for (int k = 0; k < NPH; k++) begin
        hp_d[k]  = 0.5e9 / freq_i;
        tn_d[k]  = real'(k) * 2.0 * hp_d[k] / real'(NPH);
        lvl_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < NPH; k++) begin
      for (int n = 0; n < MAX_TOG; n++) begin
        if (tn_d[k] < T_CLK_NS) begin
          lvl_d[k] = ~lvl_d[k];
          if (k == 0 && lvl_d[k]) rise_d = rise_d + 1'b1;
          hp_d[k] = 0.5e9 / freq_i;
          tn_d[k] = tn_d[k] + hp_d[k];
        end
      end
      tn_d[k] = tn_d[k] - T_CLK_NS;
    end
  end

  // Oscillator state; halted and zeroed while halt_i is high
  always_ff @(posedge clk) begin
    if (halt_i) begin
      run_q  <= 1'b0;
      lvl_q  <= '0;
      rise_q <= '0;
      for (int k = 0; k < NPH; k++) begin
        tn_q[k] <= 0.0;
        hp_q[k] <= 0.0;
      end
    end else begin
      run_q  <= 1'b1;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      for (int k = 0; k < NPH; k++) begin
        tn_q[k] <= tn_d[k];
        hp_q[k] <= hp_d[k];
      end
    end
  end

  assign oclk_o = lvl_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/vco_mp_cal.sv
// Multi-phase VCO with a binary-search coarse-band calibration engine.
// Holds the band-code register, the saturating edge counter and the FSM.
module vco_mp_cal
  import vco_pkg::*;
#(
  parameter int  CFS_W      = DEF_CFS_W,
  parameter int  NPH        = DEF_NPH,
  parameter real vin_max    = DEF_VIN_MAX,
  parameter real kvco       = DEF_KVCO,
  parameter real min_freq   = DEF_MIN_FREQ,
  parameter real step       = DEF_STEP,
  parameter int  CFS_RESET  = 0,
  parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int  WIN_CYC    = DEF_WIN_CYC,
  parameter int  CNT_W      = DEF_CNT_W,
  parameter int  TARGET_CNT = DEF_TARGET_CNT,
  parameter real T_CLK_NS   = DEF_T_CLK_NS
) (
  input  logic             clk,
  input  logic             rst,
  input  real              Voutp,
  input  real              Voutn,
  input  logic [CFS_W-1:0] cfs_in,
  input  logic             cfs_load,
  input  logic             cal_start,
  output logic             cal_busy,
  output logic             cal_done,
  output logic [CFS_W-1:0] cfs_out,
  output logic [NPH-1:0]   oclk
);

  localparam int IDX_W   = (CFS_W > 1) ? $clog2(CFS_W) : 1;
  localparam int CYC_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  cal_state_e        state_q;
  logic [CFS_W-1:0]  cfs_q, dec_code_d;
  logic [IDX_W-1:0]  bit_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_sat_d;
  logic [CNT_W:0]    cnt_sum_d;
  logic              busy_q, done_q;
  logic [RISE_W-1:0] rise;
  real               vcont, freq;

  // Control voltage: live input when idle, mid-scale during calibration
  always_comb begin
    vcont = (state_q == IDLE) ? (Voutp - Voutn) : (vin_max / 2.0);
    freq  = freq_of(vcont, 32'(cfs_q), vin_max, kvco, min_freq, step);
  end

  vco_mp_core #(
    .NPH      (NPH),
    .T_CLK_NS (T_CLK_NS)
  ) u_core (
    .clk    (clk),
    .halt_i (rst),
    .freq_i (freq),
    .oclk_o (oclk),
    .rise_o (rise)
  );

  // Saturating accumulation of oclk[0] rises and the binary-search trial step
  always_comb begin
    cnt_sum_d = {1'b0, cnt_q} + (CNT_W + 1)'(rise);
    cnt_sat_d = cnt_sum_d[CNT_W] ? '1 : cnt_sum_d[CNT_W-1:0];
    dec_code_d = cfs_q;
    if (cnt_q > CNT_W'(TARGET_CNT)) dec_code_d[bit_q] = 1'b0;
    if (bit_q != '0) dec_code_d[bit_q - IDX_W'(1)] = 1'b1;
  end

  // Calibration FSM with band-code register, edge counter and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfs_q   <= CFS_W'(CFS_RESET);
      bit_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_sat_d;
      case (state_q)
        IDLE: begin
          if (cal_start) begin
            state_q <= SETTLE;
            bit_q   <= IDX_W'(CFS_W - 1);
            cfs_q   <= CFS_W'(1) << (CFS_W - 1);
            cyc_q   <= '0;
            busy_q  <= 1'b1;
          end else if (cfs_load) begin
            cfs_q <= cfs_in;
          end
        end
        SETTLE: begin
          if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
            state_q <= COUNT;
            cyc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        COUNT: begin
          if (cyc_q == CYC_W'(WIN_CYC - 1)) begin
            state_q <= DECIDE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DECIDE: begin
          cfs_q <= dec_code_d;
          if (bit_q != '0) begin
            bit_q   <= bit_q - IDX_W'(1);
            state_q <= SETTLE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cfs_out  = cfs_q;

endmodule
